// File: rtl/alarm_pkg.sv
// Shared types and field widths for the alarm trigger slice.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;
    localparam int MAX_HOUR = 23;

endpackage

// File: rtl/alarm_trigger_if.sv
// Time/alarm/button inputs and buzzer/status outputs of the alarm trigger.
// slave is the trigger block; master is whoever drives it.
interface alarm_trigger_if;
    import alarm_pkg::*;

    logic              tick_1hz;
    logic [HOUR_W-1:0] cur_hours;
    logic [MIN_W-1:0]  cur_minutes;
    logic [SEC_W-1:0]  cur_seconds;
    logic [HOUR_W-1:0] a_hours;
    logic [MIN_W-1:0]  a_minutes;
    logic [SEC_W-1:0]  a_seconds;
    logic              alarm_en;
    logic              set_mode;
    logic              snooze_but;
    logic              stop_but;
    logic              buzzer;
    logic              alarm_active;
    logic              snoozing;
    logic [1:0]        snooze_count;

    modport master (
        output tick_1hz, cur_hours, cur_minutes, cur_seconds,
               a_hours, a_minutes, a_seconds, alarm_en, set_mode,
               snooze_but, stop_but,
        input  buzzer, alarm_active, snoozing, snooze_count
    );

    modport slave (
        input  tick_1hz, cur_hours, cur_minutes, cur_seconds,
               a_hours, a_minutes, a_seconds, alarm_en, set_mode,
               snooze_but, stop_but,
        output buzzer, alarm_active, snoozing, snooze_count
    );

endinterface

// File: rtl/alarm_match.sv
// Time-of-day vs alarm comparator with rising-edge detect, so a held
// matching time produces exactly one trigger pulse.
module alarm_match
    import alarm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    input  logic [SEC_W-1:0]  cur_seconds,
    input  logic [HOUR_W-1:0] a_hours,
    input  logic [MIN_W-1:0]  a_minutes,
    input  logic [SEC_W-1:0]  a_seconds,
    input  logic              alarm_en,
    input  logic              set_mode,
    output logic              trigger
);

    logic match;
    logic match_q;

    // Editing suppresses matching so a partially-entered time cannot fire.
    assign match = (cur_hours == a_hours) && (cur_minutes == a_minutes) &&
                   (cur_seconds == a_seconds) && alarm_en && !set_mode;

    // Previous-cycle match for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) match_q <= 1'b0;
        else        match_q <= match;
    end

    assign trigger = match && !match_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: IDLE/RINGING/SNOOZE controller driving the buzzer, with
// snooze limit, stop/disable and ring timeout. One second counter is shared
// by RINGING and SNOOZE since they are exclusive.
// Optional: define ALARM_BUZZER_PULSE_EN to beep the buzzer at 0.5 Hz while
// ringing instead of holding it steady.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    alarm_trigger_if.slave  bus
);

    localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);
    localparam logic [1:0]       MAX_SNZ     = 2'(MAX_SNOOZE);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] sec_cnt, cnt_nxt;
    logic [1:0]       snz_cnt, snz_nxt;
    logic             trigger;
    logic             buzz_nxt;
    logic             buzzer_q;
    logic             active_q;
    logic             snoozing_q;

    alarm_match u_match (
        .clk         (clk),
        .rst_n       (rst_n),
        .cur_hours   (bus.cur_hours),
        .cur_minutes (bus.cur_minutes),
        .cur_seconds (bus.cur_seconds),
        .a_hours     (bus.a_hours),
        .a_minutes   (bus.a_minutes),
        .a_seconds   (bus.a_seconds),
        .alarm_en    (bus.alarm_en),
        .set_mode    (bus.set_mode),
        .trigger     (trigger)
    );

    // State, shared second counter and snooze count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sec_cnt <= '0;
            snz_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sec_cnt <= cnt_nxt;
            snz_cnt <= snz_nxt;
        end
    end

    // Next state: stop/disable beats snooze, snooze beats timer expiry.
    // A tick in a cycle that changes state is consumed by the transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = sec_cnt;
        snz_nxt   = snz_cnt;
        if (bus.stop_but || !bus.alarm_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            snz_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state_nxt = RINGING;
                        cnt_nxt   = '0;
                        snz_nxt   = '0;
                    end
                end
                RINGING: begin
                    if (bus.snooze_but && (snz_cnt < MAX_SNZ)) begin
                        state_nxt = SNOOZE;
                        cnt_nxt   = '0;
                        snz_nxt   = snz_cnt + 2'd1;
                    end else if (bus.tick_1hz) begin
                        if (sec_cnt == RING_LAST) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = sec_cnt + CNT_W'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.tick_1hz) begin
                        if (sec_cnt == SNOOZE_LAST) begin
                            state_nxt = RINGING;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = sec_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    snz_nxt   = '0;
                end
            endcase
        end
    end

`ifdef ALARM_BUZZER_PULSE_EN
    // Beep: 1 on entering RINGING, toggle on each second while ringing.
    always_comb begin
        buzz_nxt = 1'b0;
        if (state_nxt == RINGING) begin
            if (state != RINGING)  buzz_nxt = 1'b1;
            else if (bus.tick_1hz) buzz_nxt = !buzzer_q;
            else                   buzz_nxt = buzzer_q;
        end
    end
`else
    // Steady buzzer for the whole ring period.
    always_comb begin
        buzz_nxt = (state_nxt == RINGING);
    end
`endif

    // Registered outputs, decoded from the next state so they line up
    // with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buzzer_q   <= 1'b0;
            active_q   <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            buzzer_q   <= buzz_nxt;
            active_q   <= (state_nxt != IDLE);
            snoozing_q <= (state_nxt == SNOOZE);
        end
    end

    assign bus.buzzer       = buzzer_q;
    assign bus.alarm_active = active_q;
    assign bus.snoozing     = snoozing_q;
    assign bus.snooze_count = snz_cnt;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with RING_SECS=5, SNOOZE_SECS=3,
// MAX_SNOOZE=2. A countdown-style reference model is compared every cycle;
// literal checks pin the key scenario outcomes.
module tb_alarm_trigger;

    localparam int RING   = 5;
    localparam int SNZ    = 3;
    localparam int MAXSNZ = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_on = 1'b0;

    alarm_trigger_if bus();

    alarm_trigger #(
        .RING_SECS   (RING),
        .SNOOZE_SECS (SNZ),
        .MAX_SNOOZE  (MAXSNZ)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=ringing 2=snoozing; m_left counts
    // seconds remaining in the current phase.
    int m_mode = 0;
    int m_left = 0;
    int m_snz  = 0;
    bit m_beep = 1'b0;
    bit m_prev = 1'b0;

    always @(posedge clk) begin
        bit m_match;
        bit trig;
        m_match = (bus.cur_hours == bus.a_hours) && (bus.cur_minutes == bus.a_minutes) &&
                  (bus.cur_seconds == bus.a_seconds) && bus.alarm_en && !bus.set_mode;
        if (!rst_n) begin
            m_mode = 0; m_left = 0; m_snz = 0; m_beep = 1'b0; m_prev = 1'b0;
        end else begin
            trig   = m_match && !m_prev;
            m_prev = m_match;
            if (bus.stop_but || !bus.alarm_en) begin
                m_mode = 0;
                m_snz  = 0;
            end else if (m_mode == 0) begin
                if (trig) begin
                    m_mode = 1; m_left = RING; m_snz = 0; m_beep = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (bus.snooze_but && m_snz < MAXSNZ) begin
                    m_mode = 2; m_left = SNZ; m_snz++;
                end else if (bus.tick_1hz) begin
                    m_left--;
                    m_beep = !m_beep;
                    if (m_left == 0) m_mode = 0;
                end
            end else begin
                if (bus.tick_1hz) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 1; m_left = RING; m_beep = 1'b1;
                    end
                end
            end
        end
    end

    function automatic bit exp_buzzer();
`ifdef ALARM_BUZZER_PULSE_EN
        return (m_mode == 1) && m_beep;
`else
        return (m_mode == 1);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cmp_buzzer",   int'(bus.buzzer),       int'(exp_buzzer()));
            chk("cmp_active",   int'(bus.alarm_active), int'(m_mode != 0));
            chk("cmp_snoozing", int'(bus.snoozing),     int'(m_mode == 2));
            chk("cmp_count",    int'(bus.snooze_count), m_snz);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        bus.cur_hours   = 5'(h);
        bus.cur_minutes = 6'(m);
        bus.cur_seconds = 6'(s);
    endtask

    task automatic tick();
        bus.tick_1hz = 1'b1; cyc();
        bus.tick_1hz = 1'b0; cyc();
    endtask

    task automatic snooze();
        bus.snooze_but = 1'b1; cyc();
        bus.snooze_but = 1'b0;
    endtask

    // Step time 07:29:59 -> 07:30:00; returns one cycle after the match.
    task automatic arm();
        set_time(7, 29, 59); cyc();
        set_time(7, 30, 0);  cyc();
    endtask

    initial begin
        int exp_b;
        bus.tick_1hz = 1'b0; bus.alarm_en = 1'b1; bus.set_mode = 1'b0;
        bus.snooze_but = 1'b0; bus.stop_but = 1'b0;
        bus.a_hours = 5'd7; bus.a_minutes = 6'd30; bus.a_seconds = 6'd0;
        set_time(7, 0, 0);

        // Reset state
        cyc(); cmp_on = 1'b1; cyc();
        chk("rst_buzzer", int'(bus.buzzer), 0);
        chk("rst_active", int'(bus.alarm_active), 0);
        chk("rst_count",  int'(bus.snooze_count), 0);
        rst_n = 1'b1; cyc();

        // Trigger, ring pattern, timeout, held time does not retrigger
        arm();
        chk("trig_buzzer", int'(bus.buzzer), 1);
        chk("trig_active", int'(bus.alarm_active), 1);
        for (int i = 0; i < RING; i++) begin
`ifdef ALARM_BUZZER_PULSE_EN
            exp_b = (i % 2 == 0) ? 1 : 0;
`else
            exp_b = 1;
`endif
            chk("ring_pattern", int'(bus.buzzer), exp_b);
            tick();
        end
        chk("timeout_buzzer", int'(bus.buzzer), 0);
        chk("timeout_active", int'(bus.alarm_active), 0);
        repeat (3) cyc();
        chk("hold_no_retrig", int'(bus.alarm_active), 0);

        // Snooze, snooze expiry, snooze limit
        arm();
        snooze();
        chk("snz1_snoozing", int'(bus.snoozing), 1);
        chk("snz1_count",    int'(bus.snooze_count), 1);
        chk("snz1_buzzer",   int'(bus.buzzer), 0);
        tick(); tick();
        chk("snz_mid", int'(bus.snoozing), 1);
        tick();
        chk("snz_end_snoozing", int'(bus.snoozing), 0);
        chk("snz_end_buzzer",   int'(bus.buzzer), 1);
        snooze();
        chk("snz2_count", int'(bus.snooze_count), 2);
        tick(); tick(); tick();
        snooze();
        chk("snz3_ignored_buzzer",   int'(bus.buzzer), 1);
        chk("snz3_ignored_snoozing", int'(bus.snoozing), 0);
        chk("snz3_count",            int'(bus.snooze_count), 2);

        // Stop and snooze together: stop wins
        bus.stop_but = 1'b1; bus.snooze_but = 1'b1; cyc();
        bus.stop_but = 1'b0; bus.snooze_but = 1'b0;
        chk("stop_active", int'(bus.alarm_active), 0);
        chk("stop_count",  int'(bus.snooze_count), 0);

        // set_mode and alarm_en=0 suppress triggering
        bus.set_mode = 1'b1; arm();
        chk("setmode_no_trig", int'(bus.alarm_active), 0);
        set_time(8, 0, 0); cyc(); bus.set_mode = 1'b0; cyc();
        bus.alarm_en = 1'b0; arm();
        chk("disabled_no_trig", int'(bus.alarm_active), 0);
        set_time(8, 0, 0); cyc(); bus.alarm_en = 1'b1; cyc();

        // Disable mid-snooze
        arm(); snooze(); tick();
        bus.alarm_en = 1'b0; cyc();
        chk("dis_snz_active",   int'(bus.alarm_active), 0);
        chk("dis_snz_snoozing", int'(bus.snoozing), 0);
        set_time(8, 0, 0); bus.alarm_en = 1'b1; cyc();

        // Tick in the trigger cycle is not counted: 5 more ticks to timeout
        set_time(7, 29, 59); cyc();
        set_time(7, 30, 0); bus.tick_1hz = 1'b1; cyc();
        bus.tick_1hz = 1'b0; cyc();
        chk("entry_tick_active", int'(bus.alarm_active), 1);
        repeat (RING - 1) tick();
        chk("entry_tick_still", int'(bus.alarm_active), 1);
        tick();
        chk("entry_tick_timeout", int'(bus.alarm_active), 0);

        // Reset mid-ring, then a later match triggers normally
        arm(); tick();
        rst_n = 1'b0; set_time(8, 0, 0); cyc();
        chk("midrst_buzzer", int'(bus.buzzer), 0);
        chk("midrst_active", int'(bus.alarm_active), 0);
        rst_n = 1'b1; cyc();
        arm();
        chk("after_rst_active", int'(bus.alarm_active), 1);
        chk("after_rst_buzzer", int'(bus.buzzer), 1);
        bus.stop_but = 1'b1; cyc(); bus.stop_but = 1'b0; cyc();
        chk("final_idle", int'(bus.alarm_active), 0);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
